// File: rtl/codec_sad_pkg.sv
// Shared types and width helpers for the SAD tree arbiter and its reduction tree.
package codec_sad_pkg;

    localparam int TAG_ID_W = 8;

    localparam logic [0:0] ST_FREE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Travels alongside each beat through the tree so the accumulator knows job boundaries.
    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
        logic                first;
        logic                last;
        logic                trunc;
    } sad_tag_t;

    function automatic int lat_of(input int n);
        return $clog2(n);
    endfunction

    function automatic int acc_w_of(input int dw, input int n, input int beats_w);
        return dw + $clog2(n) + beats_w;
    endfunction

endpackage

// File: rtl/codec_sad_tree_arb_if.sv
// Requester beat handshake and tagged result bus of the SAD tree arbiter.
interface codec_sad_tree_arb_if #(
    parameter int NREQ    = 4,
    parameter int N       = 16,
    parameter int DW      = 16,
    parameter int BEATS_W = 4
);
    import codec_sad_pkg::*;

    localparam int ACC_W = acc_w_of(DW, N, BEATS_W);
    localparam int IDW   = $clog2(NREQ);

    // A beat transfers on a cycle where req_vld[i] && req_rdy[i]; req_rdy never
    // waits on anything but arbitration. res_vld is a one-cycle pulse with no backpressure.
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*N*DW-1:0] req_data;
    logic [NREQ-1:0]      req_rdy;
    logic                 res_vld;
    logic [IDW-1:0]       res_id;
    logic [ACC_W-1:0]     res_sum;
    logic                 res_trunc;

    modport master (
        output req_vld, req_last, req_data,
        input  req_rdy, res_vld, res_id, res_sum, res_trunc
    );

    modport slave (
        input  req_vld, req_last, req_data,
        output req_rdy, res_vld, res_id, res_sum, res_trunc
    );

endinterface

// File: rtl/codec_cmm_adder_tree.sv
// Pipelined N-input adder tree: one register level per tree level, latency $clog2(N).
module codec_cmm_adder_tree #(
    parameter int N  = 16,
    parameter int DW = 16,
    localparam int LAT = $clog2(N),
    localparam int SW  = DW + LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [N*DW-1:0]   in_data,
    output logic              out_vld,
    output logic [SW-1:0]     out_sum
);

    // Heap layout: node i has children 2i and 2i+1; leaves N..2N-1 are the raw lanes.
    logic [SW-1:0]  node  [1:2*N-1];
    logic [SW-1:0]  sum_q [1:N-1];
    logic [LAT-1:0] vld_q;

    for (genvar i = 1; i < 2*N; i++) begin : g_node
        if (i < N) begin : g_inner
            assign node[i] = sum_q[i];
        end else begin : g_leaf
            assign node[i] = SW'(in_data[(i-N)*DW +: DW]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < N; i++) sum_q[i] <= '0;
            vld_q <= '0;
        end else begin
            for (int i = 1; i < N; i++) sum_q[i] <= node[2*i] + node[2*i+1];
            vld_q[0] <= in_vld;
            for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_sum = sum_q[1];

endmodule

// File: rtl/codec_sad_tree_arb.sv
// Round-robin job arbiter in front of a shared adder tree; accumulates per-job sums and tags results.
module codec_sad_tree_arb
    import codec_sad_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int N       = 16,
    parameter int DW      = 16,
    parameter int BEATS_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_en,
    codec_sad_tree_arb_if.slave       bus,
    output logic                      idle,
    output logic [0:0]                dbg_state,
    output logic [$clog2(NREQ)-1:0]   dbg_rr_ptr
);

    localparam int LAT   = lat_of(N);
    localparam int ACC_W = acc_w_of(DW, N, BEATS_W);
    localparam int IDW   = $clog2(NREQ);
    localparam int SW    = DW + LAT;
    localparam logic [BEATS_W-1:0] CNT_MAX = '1;

    logic [0:0]         state;
    logic [IDW-1:0]     owner, rr_ptr, cur_id;
    logic [BEATS_W-1:0] beat_cnt;
    logic [NREQ-1:0]    req_rdy_c;
    logic               beat_acc, beat_first, beat_last, beat_trunc;
    logic [N*DW-1:0]    tree_data;
    logic               tree_vld;
    logic [SW-1:0]      tree_sum;
    sad_tag_t           tag_in;
    sad_tag_t           tag_q [LAT];
    sad_tag_t           out_tag;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic               tag_busy;

    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] vld, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && vld[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // In FREE the winner is granted combinationally so the first beat costs no bubble.
    always_comb begin
        cur_id    = owner;
        req_rdy_c = '0;
        if (state == ST_FREE) begin
            cur_id = rr_pick(bus.req_vld, rr_ptr);
            if (cfg_en && |bus.req_vld) req_rdy_c[cur_id] = 1'b1;
        end else begin
            req_rdy_c[owner] = bus.req_vld[owner];
        end
        if (rst) req_rdy_c = '0;
    end

    assign bus.req_rdy = req_rdy_c;
    assign beat_acc    = |req_rdy_c;
    assign beat_first  = (beat_cnt == '0);
    assign beat_trunc  = (beat_cnt == CNT_MAX);
    assign beat_last   = bus.req_last[cur_id] | beat_trunc;
    assign tree_data   = bus.req_data[cur_id*N*DW +: N*DW];

    always_comb begin
        tag_in.vld   = beat_acc;
        tag_in.id    = TAG_ID_W'(cur_id);
        tag_in.first = beat_first;
        tag_in.last  = beat_last;
        tag_in.trunc = beat_trunc;
    end

    codec_cmm_adder_tree #(.N(N), .DW(DW)) u_tree (
        .clk     (clk),
        .rst_n   (~rst),
        .in_vld  (beat_acc),
        .in_data (tree_data),
        .out_vld (tree_vld),
        .out_sum (tree_sum)
    );

    assign out_tag = tag_q[LAT-1];
    assign acc_nxt = (out_tag.first ? '0 : acc) + ACC_W'(tree_sum);

    always_comb begin
        tag_busy = 1'b0;
        for (int k = 0; k < LAT; k++) tag_busy = tag_busy | tag_q[k].vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FREE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            acc           <= '0;
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
            bus.res_vld   <= 1'b0;
            bus.res_id    <= '0;
            bus.res_sum   <= '0;
            bus.res_trunc <= 1'b0;
        end else begin
            if (beat_acc) begin
                if (beat_last) begin
                    state    <= ST_FREE;
                    beat_cnt <= '0;
                    rr_ptr   <= (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
                end else begin
                    state    <= ST_LOCKED;
                    owner    <= cur_id;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            tag_q[0] <= tag_in;
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
            bus.res_vld <= 1'b0;
            if (out_tag.vld && tree_vld) begin
                acc <= acc_nxt;
                if (out_tag.last) begin
                    bus.res_vld   <= 1'b1;
                    bus.res_id    <= out_tag.id[IDW-1:0];
                    bus.res_sum   <= acc_nxt;
                    bus.res_trunc <= out_tag.trunc;
                end
            end
        end
    end

    assign idle       = (state == ST_FREE) && !tag_busy && !bus.res_vld;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_codec_sad_tree_arb.sv
// Directed bench for codec_sad_tree_arb with hand-computed sums, result cycles and grant patterns.
module tb_codec_sad_tree_arb;
    import codec_sad_pkg::*;

    localparam int NREQ = 4, N = 16, DW = 16, BEATS_W = 4;
    localparam int ACC_W = 24, IDW = 2;

    typedef struct {
        int               cyc;
        logic [IDW-1:0]   id;
        logic [ACC_W-1:0] sum;
        logic             trunc;
    } res_t;

    logic           clk = 1'b0;
    logic           rst, cfg_en;
    logic           idle;
    logic [0:0]     dbg_state;
    logic [IDW-1:0] dbg_rr_ptr;
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_bad = 0;
    res_t           res_q[$];
    logic [ACC_W-1:0] exp_q[$];

    codec_sad_tree_arb_if #(.NREQ(NREQ), .N(N), .DW(DW), .BEATS_W(BEATS_W)) bus ();

    codec_sad_tree_arb #(.NREQ(NREQ), .N(N), .DW(DW), .BEATS_W(BEATS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .bus        (bus),
        .idle       (idle),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus.res_vld === 1'b1) res_q.push_back('{cyc, bus.res_id, bus.res_sum, bus.res_trunc});

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*DW-1:0] lanes(input logic [DW-1:0] v);
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = v;
        return d;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_vld  = '0;
        bus.req_last = '0;
        bus.req_data = '0;
    endtask

    task automatic set_beat(input int r, input logic [DW-1:0] v, input logic last);
        bus.req_vld[r]  = 1'b1;
        bus.req_last[r] = last;
        bus.req_data[r*N*DW +: N*DW] = lanes(v);
    endtask

    task automatic wait_res(input int n);
        for (int k = 0; k < 40 && res_q.size() < n; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_en = 1'b1;
        bus.req_vld = 4'b1111;
        repeat (2) tick();
        n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset_rdy: got %b want 0000", bus.req_rdy); end
        n_cmp++; if (bus.res_vld !== 1'b0) begin n_bad++; $display("FAIL reset_res_vld: got %b want 0", bus.res_vld); end
        n_cmp++; if (bus.res_id !== 2'd0) begin n_bad++; $display("FAIL reset_res_id: got %0d want 0", bus.res_id); end
        n_cmp++; if (bus.res_sum !== 24'd0) begin n_bad++; $display("FAIL reset_res_sum: got %0d want 0", bus.res_sum); end
        n_cmp++; if (bus.res_trunc !== 1'b0) begin n_bad++; $display("FAIL reset_res_trunc: got %b want 0", bus.res_trunc); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_cmp++; if (dbg_rr_ptr !== 2'd0) begin n_bad++; $display("FAIL reset_rr_ptr: got %0d want 0", dbg_rr_ptr); end
        clear_req();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int t, s0, s2;
        res_t r;
        logic [ACC_W-1:0] e;
        s0 = 0; s2 = 0;
        exp_q.push_back(24'd240);
        exp_q.push_back(24'd336);
        for (int i = 0; i < 6; i++) begin
            bus.req_vld[0]  = (s0 < 3);
            bus.req_last[0] = (s0 == 2);
            bus.req_data[0 +: N*DW] = lanes(16'd5);
            bus.req_vld[2]  = (s2 < 3);
            bus.req_last[2] = (s2 == 2);
            bus.req_data[2*N*DW +: N*DW] = lanes(16'd7);
            #1;
            if (i == 0) t = cyc;
            n_cmp++;
            if (bus.req_rdy !== ((i < 3) ? 4'b0001 : 4'b0100)) begin
                n_bad++; $display("FAIL contention_rdy[%0d]: got %b want %b", i, bus.req_rdy, (i < 3) ? 4'b0001 : 4'b0100);
            end
            if (bus.req_rdy[0]) s0++;
            if (bus.req_rdy[2]) s2++;
            tick();
        end
        clear_req();
        n_cmp++; if (dbg_rr_ptr !== 2'd3) begin n_bad++; $display("FAIL contention_rr_ptr: got %0d want 3", dbg_rr_ptr); end
        wait_res(2);
        n_cmp++;
        if (res_q.size() < 2) begin
            n_bad++; $display("FAIL contention_count: got %0d want 2", res_q.size());
            exp_q.delete();
        end else begin
            r = res_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (r.cyc !== t + 7) begin n_bad++; $display("FAIL contention_cyc0: got %0d want %0d", r.cyc, t + 7); end
            n_cmp++; if (r.id !== 2'd0) begin n_bad++; $display("FAIL contention_id0: got %0d want 0", r.id); end
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL contention_sum0: got %0d want %0d", r.sum, e); end
            r = res_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (r.cyc !== t + 10) begin n_bad++; $display("FAIL contention_cyc2: got %0d want %0d", r.cyc, t + 10); end
            n_cmp++; if (r.id !== 2'd2) begin n_bad++; $display("FAIL contention_id2: got %0d want 2", r.id); end
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL contention_sum2: got %0d want %0d", r.sum, e); end
        end
    endtask

    task automatic test_single();
        int t;
        res_t r;
        logic [ACC_W-1:0] e;
        exp_q.push_back(24'd16);
        set_beat(0, 16'd1, 1'b1);
        #1;
        t = cyc;
        n_cmp++; if (bus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL single_rdy: got %b want 0001", bus.req_rdy); end
        tick();
        clear_req();
        n_cmp++; if (dbg_state !== ST_FREE) begin n_bad++; $display("FAIL single_state: got %b want FREE", dbg_state); end
        n_cmp++; if (dbg_rr_ptr !== 2'd1) begin n_bad++; $display("FAIL single_rr_ptr: got %0d want 1", dbg_rr_ptr); end
        wait_res(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (res_q.size() < 1) begin
            n_bad++; $display("FAIL single_timeout: got 0 results want 1");
        end else begin
            r = res_q.pop_front();
            n_cmp++; if (r.cyc !== t + 5) begin n_bad++; $display("FAIL single_cyc: got %0d want %0d", r.cyc, t + 5); end
            n_cmp++; if (r.id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", r.id); end
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL single_sum: got %0d want %0d", r.sum, e); end
            n_cmp++; if (r.trunc !== 1'b0) begin n_bad++; $display("FAIL single_trunc: got %b want 0", r.trunc); end
        end
    endtask

    task automatic test_two_beat();
        int t;
        res_t r;
        logic [ACC_W-1:0] e;
        exp_q.push_back(24'd4800);
        set_beat(1, 16'd100, 1'b0);
        #1;
        n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL two_rdy0: got %b want 0010", bus.req_rdy); end
        tick();
        // Owner pauses while another requester asks: the lock must hold.
        bus.req_vld = 4'b0100;
        #1;
        n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL two_gap_rdy: got %b want 0000", bus.req_rdy); end
        n_cmp++; if (dbg_state !== ST_LOCKED) begin n_bad++; $display("FAIL two_gap_state: got %b want LOCKED", dbg_state); end
        tick();
        bus.req_vld = 4'b0001;
        set_beat(1, 16'd200, 1'b1);
        #1;
        t = cyc;
        n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL two_rdy1: got %b want 0010", bus.req_rdy); end
        tick();
        clear_req();
        wait_res(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (res_q.size() < 1) begin
            n_bad++; $display("FAIL two_timeout: got 0 results want 1");
        end else begin
            r = res_q.pop_front();
            n_cmp++; if (r.cyc !== t + 5) begin n_bad++; $display("FAIL two_cyc: got %0d want %0d", r.cyc, t + 5); end
            n_cmp++; if (r.id !== 2'd1) begin n_bad++; $display("FAIL two_id: got %0d want 1", r.id); end
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL two_sum: got %0d want %0d", r.sum, e); end
        end
        repeat (8) tick();
        n_cmp++; if (res_q.size() !== 0) begin n_bad++; $display("FAIL two_extra: got %0d extra results want 0", res_q.size()); end
    endtask

    task automatic test_trunc();
        int t;
        res_t r;
        logic [ACC_W-1:0] e;
        exp_q.push_back(24'd16776960);
        exp_q.push_back(24'd1048560);
        for (int i = 0; i < 17; i++) begin
            set_beat(3, 16'hFFFF, i == 16);
            #1;
            if (i == 0) t = cyc;
            n_cmp++; if (bus.req_rdy !== 4'b1000) begin n_bad++; $display("FAIL trunc_rdy[%0d]: got %b want 1000", i, bus.req_rdy); end
            tick();
        end
        clear_req();
        n_cmp++; if (dbg_rr_ptr !== 2'd0) begin n_bad++; $display("FAIL trunc_rr_ptr: got %0d want 0", dbg_rr_ptr); end
        wait_res(2);
        n_cmp++;
        if (res_q.size() < 2) begin
            n_bad++; $display("FAIL trunc_count: got %0d want 2", res_q.size());
            exp_q.delete();
        end else begin
            r = res_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (r.cyc !== t + 20) begin n_bad++; $display("FAIL trunc_cyc0: got %0d want %0d", r.cyc, t + 20); end
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL trunc_sum0: got %0d want %0d", r.sum, e); end
            n_cmp++; if (r.trunc !== 1'b1) begin n_bad++; $display("FAIL trunc_flag0: got %b want 1", r.trunc); end
            n_cmp++; if (r.id !== 2'd3) begin n_bad++; $display("FAIL trunc_id0: got %0d want 3", r.id); end
            r = res_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (r.cyc !== t + 21) begin n_bad++; $display("FAIL trunc_cyc1: got %0d want %0d", r.cyc, t + 21); end
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL trunc_sum1: got %0d want %0d", r.sum, e); end
            n_cmp++; if (r.trunc !== 1'b0) begin n_bad++; $display("FAIL trunc_flag1: got %b want 0", r.trunc); end
        end
    endtask

    task automatic test_cfg_en();
        res_t r;
        logic [ACC_W-1:0] e;
        exp_q.push_back(24'd144);
        exp_q.push_back(24'd32);
        for (int i = 0; i < 3; i++) begin
            set_beat(1, 16'd3, i == 2);
            #1;
            n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL cfg_job_rdy[%0d]: got %b want 0010", i, bus.req_rdy); end
            tick();
            cfg_en = 1'b0;
        end
        set_beat(1, 16'd3, 1'b1);
        set_beat(0, 16'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL cfg_block_rdy[%0d]: got %b want 0000", i, bus.req_rdy); end
            tick();
        end
        wait_res(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (res_q.size() < 1) begin
            n_bad++; $display("FAIL cfg_timeout: got 0 results want 1");
        end else begin
            r = res_q.pop_front();
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL cfg_sum: got %0d want %0d", r.sum, e); end
            n_cmp++; if (r.id !== 2'd1) begin n_bad++; $display("FAIL cfg_id: got %0d want 1", r.id); end
        end
        for (int k = 0; k < 10 && idle !== 1'b1; k++) tick();
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL cfg_idle: got %b want 1", idle); end
        n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL cfg_idle_rdy: got %b want 0000", bus.req_rdy); end
        cfg_en = 1'b1;
        #1;
        n_cmp++; if (bus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL cfg_resume_rdy: got %b want 0001", bus.req_rdy); end
        tick();
        clear_req();
        wait_res(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (res_q.size() < 1) begin
            n_bad++; $display("FAIL cfg_resume_timeout: got 0 results want 1");
        end else begin
            r = res_q.pop_front();
            n_cmp++; if (r.sum !== e) begin n_bad++; $display("FAIL cfg_resume_sum: got %0d want %0d", r.sum, e); end
            n_cmp++; if (r.id !== 2'd0) begin n_bad++; $display("FAIL cfg_resume_id: got %0d want 0", r.id); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_beat(2, 16'd9, i == 2);
            tick();
        end
        clear_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got %b want 1", idle); end
        n_cmp++; if (dbg_state !== ST_FREE) begin n_bad++; $display("FAIL rstmid_state: got %b want FREE", dbg_state); end
        n_cmp++; if (dbg_rr_ptr !== 2'd0) begin n_bad++; $display("FAIL rstmid_rr_ptr: got %0d want 0", dbg_rr_ptr); end
        repeat (10) tick();
        n_cmp++; if (res_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_results: got %0d want 0", res_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        cfg_en = 1'b1;
        clear_req();
        test_reset();
        test_contention();
        test_single();
        test_two_beat();
        test_trunc();
        test_cfg_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/codec_sad_tree_arb.md
# codec_sad_tree_arb

Round-robin arbiter and job sequencer that shares one pipelined N-input adder tree between NREQ SAD engines. Each requester submits a job of one or more beats, where a beat is N lanes of DW-bit absolute differences. The block locks the tree to the requester for the whole job, accumulates the per-beat tree sums, and returns one tagged result per job. It sits between the motion-search SAD engines and the shared reduction datapath.

## Interface
- `NREQ`, default 4: number of requesters, at least 2.
- `N`, default 16: lanes per beat; must be a power of 2.
- `DW`, default 16: lane width.
- `BEATS_W`, default 4: the maximum job length is 2^BEATS_W beats.
- Derived: `LAT = $clog2(N)` is the tree latency. `ACC_W = DW + $clog2(N) + BEATS_W`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous reset, active-high.
- `cfg_en`, in, 1: arbitration enable.
- `req_vld`, in, NREQ: beat valid, one bit per requester.
- `req_last`, in, NREQ: last beat of the job, one bit per requester.
- `req_data`, in, NREQ*N*DW: beat data; requester i occupies slice `[i*N*DW +: N*DW]`.
- `req_rdy`, out, NREQ: beat accepted, one bit per requester.
- `res_vld`, out, 1: single-cycle result pulse. There is no backpressure on results.
- `res_id`, out, $clog2(NREQ): index of the requester that owns the result.
- `res_sum`, out, ACC_W: job sum.
- `res_trunc`, out, 1: the job was cut at 2^BEATS_W beats.
- `idle`, out, 1: no lock is held and nothing is in flight.

## Operation
- **Arbitration states.**
  - FREE: no lock is held. If `cfg_en` is high and any `req_vld` is high, grant the first requester at or after `rr_ptr` in round-robin order. `req_rdy` for that requester is high in the same cycle, so the first beat is accepted with no bubble. Go to LOCKED unless that beat is last.
  - LOCKED(owner): only `req_rdy[owner]` may be high, and it equals `req_vld[owner]`. When a last beat is accepted, go to FREE and set `rr_ptr = owner + 1`, modulo NREQ.
- **cfg_en.** Low blocks new grants in FREE only. A locked job always runs to completion.
- **Beat counter.** Counts beats accepted in the current job. The beat that takes the count to 2^BEATS_W is treated as last, regardless of `req_last`, and is tagged `trunc`. Any further beats from the requester start a new job.
- **Tree feed.** An accepted beat drives the tree input with valid=1 and the owner's data. All other cycles drive valid=0.
- **Tag pipeline.** LAT stages, each holding {vld, id, first, last, trunc}, advance every cycle in step with the tree.
- **Accumulator.** On a tree output with tag.vld set:
  - `acc = (tag.first ? 0 : acc) + tree_sum`.
  - If tag.last, register `res_vld=1`, `res_id=tag.id`, `res_sum` = the new acc, and `res_trunc=tag.trunc`.
- **Width.** Arithmetic is unsigned and zero-extended to ACC_W. There is no overflow by construction.
- **Job ordering.** Jobs from different requesters may be in the tree at the same time. Results come out in acceptance order.
- **idle.** High when the state is FREE, no tag stage is valid, and `res_vld` is 0.

## Timing
- A beat accepted in cycle t appears at the tree output in cycle t+LAT.
- A job whose last beat is accepted in cycle t produces `res_vld` in cycle t+LAT+1.
- Throughput is one beat per cycle, including back-to-back jobs from different requesters.
- Reset values: `req_rdy=0`, `res_vld=0`, `res_id=0`, `res_sum=0`, `res_trunc=0`, `idle=1`. Also state FREE, `rr_ptr=0`, beat counter 0, acc 0, and all tag stages invalid.
- Reset mid-job: all in-flight beats are dropped and no `res_vld` is produced. The tree's active-low reset is driven by `~rst`.
- `req_vld` and `req_last` both high on a single-beat job: accepted, lock is not taken, and the state stays FREE.
- A requester may deassert `req_vld` while the lock is held. The lock persists through the gap.

## Structure
- Shared package `codec_sad_pkg` holds:
  - the tag struct {vld, id, first, last, trunc};
  - the LAT and ACC_W width helper functions.
- Sub-module: instantiate the existing `codec_cmm_adder_tree` with parameters N and DW. This block adds only arbitration, tagging and accumulation.
- Round-robin pick is a local function; no separate module.

## Test plan
All scenarios use N=16, DW=16, NREQ=4, BEATS_W=4, LAT=4.
- **Single beat:** requester 0 sends one beat, all lanes 1, last=1, at t → `res_vld` at t+5 with `res_id=0`, `res_sum=16`, `res_trunc=0`.
- **Two-beat job:** requester 1 sends lanes 100, then lanes 200 with last → `res_sum=4800`, `res_id=1`, exactly one `res_vld`.
- **Contention:** requesters 0 and 2 request 3-beat jobs simultaneously with `rr_ptr=0` → requester 0 is accepted for cycles t..t+2 and requester 2 for t+3..t+5. Results for id 0 then id 2 arrive at t+7 and t+10. `rr_ptr` ends at 3.
- **Full-scale and truncation:** requester 3 sends 17 beats with lanes 0xFFFF and `req_last` only on beat 17 → the first result has `res_sum=16776960` and `res_trunc=1`. The second result is a 1-beat job with `res_sum=1048560` and `res_trunc=0`.
- **cfg_en:** `cfg_en` drops during a locked job → that job completes. Then `req_rdy` stays 0 until `cfg_en` returns, and `idle` goes to 1.
- **Reset mid-job:** `rst` pulses with 3 beats in flight → no `res_vld` afterwards, and `idle=1` in the cycle after `rst` deasserts.
